// File: rtl/bus_arbiter_if.sv
// Signal bundle between two bus masters, the shared memory bus, the register
// slave and the arbiter. The arbiter connects through the slave modport.
interface bus_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  // Handshake: a master raises cs with we/addr/dat stable and holds them until
  // its one-cycle ack strobe; dropping cs earlier abandons the access without an
  // ack. The memory bus and register slave complete by pulsing their own ack
  // while the matching select is high; read data is only meaningful with ack.
  logic          i_m0_cs;
  logic          i_m0_we;
  logic [AW-1:0] i_m0_addr;
  logic [DW-1:0] i_m0_dat;
  logic          o_m0_ack;
  logic          i_m1_cs;
  logic          i_m1_we;
  logic [AW-1:0] i_m1_addr;
  logic [DW-1:0] i_m1_dat;
  logic          o_m1_ack;
  logic [DW-1:0] o_rd_dat;
  logic          o_cs;
  logic          o_we;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_dat;
  logic [DW-1:0] i_dat;
  logic          i_ack;
  logic          o_reg_cs;
  logic [DW-1:0] i_reg_dat;
  logic          i_reg_ack;
  logic [1:0]    o_grant;
  logic          o_err;

  modport slave (
    input  i_m0_cs, i_m0_we, i_m0_addr, i_m0_dat,
    input  i_m1_cs, i_m1_we, i_m1_addr, i_m1_dat,
    input  i_dat, i_ack, i_reg_dat, i_reg_ack,
    output o_m0_ack, o_m1_ack, o_rd_dat, o_cs, o_we, o_addr, o_dat,
    output o_reg_cs, o_grant, o_err
  );

  modport master (
    output i_m0_cs, i_m0_we, i_m0_addr, i_m0_dat,
    output i_m1_cs, i_m1_we, i_m1_addr, i_m1_dat,
    output i_dat, i_ack, i_reg_dat, i_reg_ack,
    input  o_m0_ack, o_m1_ack, o_rd_dat, o_cs, o_we, o_addr, o_dat,
    input  o_reg_cs, o_grant, o_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master arbiter for one shared memory bus with a two-byte register window.
// Optional ack-wait timeout is enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter #(
  parameter int              AW         = 16,
  parameter int              DW         = 8,
  parameter logic [AW-1:0]   REG_BASE   = 16'hFFF0,
  parameter int              M0_MAX_RUN = 8
`ifdef ARB_TIMEOUT_EN
  , parameter int            TIMEOUT    = 64
`endif
) (
  input  logic       i_clk,
  input  logic       i_reset,
  bus_arbiter_if.slave bus,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [7:0]    run, run_nx;
  logic          granted;
  logic          sel_m1;
  logic          cur_cs;
  logic          cur_we;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_dat;
  logic          reg_hit;
  logic          ack_src;
  logic [DW-1:0] rd_src;
  logic          expired;
  logic          ack;

  assign granted  = (state == GNT0) || (state == GNT1);
  assign sel_m1   = (state == GNT1);
  assign cur_cs   = sel_m1 ? bus.i_m1_cs   : bus.i_m0_cs;
  assign cur_we   = sel_m1 ? bus.i_m1_we   : bus.i_m0_we;
  assign cur_addr = sel_m1 ? bus.i_m1_addr : bus.i_m0_addr;
  assign cur_dat  = sel_m1 ? bus.i_m1_dat  : bus.i_m0_dat;
  assign reg_hit  = (cur_addr[AW-1:1] == REG_BASE[AW-1:1]);
  assign ack_src  = reg_hit ? bus.i_reg_ack : bus.i_ack;
  assign rd_src   = reg_hit ? bus.i_reg_dat : bus.i_dat;
  assign o_state  = state;

`ifdef ARB_TIMEOUT_EN
  // Counts cycles already spent in the current grant; idle states hold it at 0.
  logic [7:0] wait_cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)     wait_cnt <= '0;
    else if (granted) wait_cnt <= wait_cnt + 8'd1;
    else              wait_cnt <= '0;
  end

  assign expired = granted && (wait_cnt == 8'(TIMEOUT - 1));
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
      run   <= '0;
    end else begin
      state <= state_nx;
      run   <= run_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    run_nx       = run;
    ack          = 1'b0;
    bus.o_rd_dat = '0;
    bus.o_cs     = 1'b0;
    bus.o_we     = 1'b0;
    bus.o_reg_cs = 1'b0;
    bus.o_addr   = '0;
    bus.o_dat    = '0;
    bus.o_grant  = 2'b00;
    bus.o_err    = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.i_m1_cs) run_nx = '0;
        if (bus.i_m1_cs && (!bus.i_m0_cs || run == 8'(M0_MAX_RUN))) begin
          state_nx = GNT1;
          run_nx   = '0;
        end else if (bus.i_m0_cs) begin
          state_nx = GNT0;
          if (bus.i_m1_cs && run != 8'hFF) run_nx = run + 8'd1;
        end
      end
      GNT0, GNT1: begin
        bus.o_grant = sel_m1 ? 2'b10 : 2'b01;
        bus.o_addr  = cur_addr;
        bus.o_dat   = cur_dat;
        // Selects drop in the same cycle as an abort or a timeout.
        if (cur_cs && !(expired && !ack_src)) begin
          bus.o_we     = cur_we;
          bus.o_cs     = !reg_hit;
          bus.o_reg_cs = reg_hit;
        end
        if (!cur_cs) begin
          state_nx = DONE;
        end else if (ack_src) begin
          ack          = 1'b1;
          bus.o_rd_dat = rd_src;
          state_nx     = DONE;
        end else if (expired) begin
          ack          = 1'b1;
          bus.o_err    = 1'b1;
          bus.o_rd_dat = {DW{1'b1}};
          state_nx     = DONE;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.o_m0_ack = ack && !sel_m1;
  assign bus.o_m1_ack = ack &&  sel_m1;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, reads, priority, starvation limit,
// register window, mid-access reset and the ack-wait timeout / abort paths.
module tb_bus_arbiter;
  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         total;
  int         bad;

  bus_arbiter_if #(.AW(16), .DW(8)) bus ();

  bus_arbiter dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus),
    .o_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic idle_inputs();
    bus.i_m0_cs = 0; bus.i_m0_we = 0; bus.i_m0_addr = '0; bus.i_m0_dat = '0;
    bus.i_m1_cs = 0; bus.i_m1_we = 0; bus.i_m1_addr = '0; bus.i_m1_dat = '0;
    bus.i_dat = '0; bus.i_ack = 0; bus.i_reg_dat = '0; bus.i_reg_ack = 0;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    settle(3);
    #1;
    total++; if (bus.o_grant !== 2'b00) begin bad++; $display("FAIL rst_grant: got %b want 00", bus.o_grant); end
    total++; if ({bus.o_cs, bus.o_we, bus.o_reg_cs, bus.o_m0_ack, bus.o_m1_ack, bus.o_err} !== 6'b0) begin
      bad++; $display("FAIL rst_ctrl: got %b want 000000", {bus.o_cs, bus.o_we, bus.o_reg_cs, bus.o_m0_ack, bus.o_m1_ack, bus.o_err}); end
    total++; if ({bus.o_addr, bus.o_dat, bus.o_rd_dat} !== 32'h0) begin
      bad++; $display("FAIL rst_data: got %h want 0", {bus.o_addr, bus.o_dat, bus.o_rd_dat}); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // m0 read of 0x1234, memory acks on the third grant cycle with 8'hA5.
  task automatic test_m0_read();
    int cs_cycles;
    cs_cycles = 0;
    @(negedge clk);
    bus.i_m0_cs = 1; bus.i_m0_we = 0; bus.i_m0_addr = 16'h1234; bus.i_m0_dat = 8'h99;
    #1;
    total++; if (bus.o_cs !== 1'b0) begin bad++; $display("FAIL t1_idle_cs: got %b want 0", bus.o_cs); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 2) begin bus.i_ack = 1; bus.i_dat = 8'hA5; end
      #1;
      if (bus.o_cs === 1'b1) cs_cycles++;
      if (k == 0) begin
        total++; if (bus.o_addr !== 16'h1234) begin bad++; $display("FAIL t1_addr: got %h want 1234", bus.o_addr); end
        total++; if (bus.o_we !== 1'b0) begin bad++; $display("FAIL t1_we: got %b want 0", bus.o_we); end
      end
      total++; if (bus.o_grant !== 2'b01) begin bad++; $display("FAIL t1_grant_%0d: got %b want 01", k, bus.o_grant); end
      if (k < 2) begin
        total++; if (bus.o_m0_ack !== 1'b0) begin bad++; $display("FAIL t1_early_ack_%0d: got %b want 0", k, bus.o_m0_ack); end
        total++; if (bus.o_rd_dat !== 8'h00) begin bad++; $display("FAIL t1_rd_idle_%0d: got %h want 00", k, bus.o_rd_dat); end
      end else begin
        total++; if (bus.o_m0_ack !== 1'b1) begin bad++; $display("FAIL t1_ack: got %b want 1", bus.o_m0_ack); end
        total++; if (bus.o_rd_dat !== 8'hA5) begin bad++; $display("FAIL t1_rd_dat: got %h want a5", bus.o_rd_dat); end
      end
    end
    @(negedge clk);
    bus.i_m0_cs = 0; bus.i_ack = 0; bus.i_dat = 8'h00;
    #1;
    if (bus.o_cs === 1'b1) cs_cycles++;
    total++; if (bus.o_grant !== 2'b00) begin bad++; $display("FAIL t1_done_grant: got %b want 00", bus.o_grant); end
    total++; if (cs_cycles !== 3) begin bad++; $display("FAIL t1_cs_cycles: got %0d want 3", cs_cycles); end
    settle(1);
  endtask

  // Simultaneous requests: m0 first, m1 granted after DONE and one IDLE cycle.
  task automatic test_simultaneous();
    @(negedge clk);
    bus.i_m0_cs = 1; bus.i_m0_addr = 16'h0100;
    bus.i_m1_cs = 1; bus.i_m1_addr = 16'h0200;
    @(negedge clk);
    bus.i_ack = 1; bus.i_dat = 8'h42;
    #1;
    total++; if (bus.o_grant !== 2'b01) begin bad++; $display("FAIL t2_first: got %b want 01", bus.o_grant); end
    total++; if ({bus.o_m1_ack, bus.o_m0_ack} !== 2'b01) begin bad++; $display("FAIL t2_ack0: got %b want 01", {bus.o_m1_ack, bus.o_m0_ack}); end
    @(negedge clk);
    bus.i_m0_cs = 0; bus.i_ack = 0;
    #1;
    total++; if (bus.o_grant !== 2'b00) begin bad++; $display("FAIL t2_done: got %b want 00", bus.o_grant); end
    @(negedge clk);
    @(negedge clk);
    bus.i_ack = 1; bus.i_dat = 8'h24;
    #1;
    total++; if (bus.o_grant !== 2'b10) begin bad++; $display("FAIL t2_second: got %b want 10", bus.o_grant); end
    total++; if (bus.o_addr !== 16'h0200) begin bad++; $display("FAIL t2_addr1: got %h want 0200", bus.o_addr); end
    total++; if ({bus.o_m1_ack, bus.o_m0_ack, bus.o_rd_dat} !== {2'b10, 8'h24}) begin
      bad++; $display("FAIL t2_ack1: got %b/%h want 10/24", {bus.o_m1_ack, bus.o_m0_ack}, bus.o_rd_dat); end
    @(negedge clk);
    bus.i_m1_cs = 0; bus.i_ack = 0;
    settle(2);
  endtask

  // m0 holds cs, m1 waits: expect 8 m0 grants, one m1 grant, then m0 again.
  task automatic test_starvation();
    logic [1:0] seq[$];
    int  stray;
    int  lead;
    bit  drop_m1;
    stray = 0; lead = 0; drop_m1 = 0;
    @(negedge clk);
    bus.i_m0_cs = 1; bus.i_m0_addr = 16'h0010;
    bus.i_m1_cs = 1; bus.i_m1_addr = 16'h0020;
    bus.i_ack = 1; bus.i_dat = 8'h11;
    for (int c = 0; c < 100 && seq.size() < 10; c++) begin
      @(negedge clk);
      if (drop_m1) begin bus.i_m1_cs = 0; drop_m1 = 0; end
      #1;
      if (bus.o_grant !== 2'b00) seq.push_back(bus.o_grant);
      if (bus.o_grant === 2'b10) drop_m1 = 1;
      if (bus.o_grant === 2'b00 && (bus.o_m0_ack || bus.o_m1_ack)) stray++;
    end
    total++; if (seq.size() !== 10) begin bad++; $display("FAIL t3_grant_count: got %0d want 10", seq.size()); end
    while (lead < seq.size() && seq[lead] == 2'b01) lead++;
    total++; if (lead !== 8) begin bad++; $display("FAIL t3_m0_run: got %0d want 8", lead); end
    if (seq.size() == 10) begin
      total++; if (seq[8] !== 2'b10) begin bad++; $display("FAIL t3_m1_turn: got %b want 10", seq[8]); end
      total++; if (seq[9] !== 2'b01) begin bad++; $display("FAIL t3_m0_resume: got %b want 01", seq[9]); end
    end
    total++; if (stray !== 0) begin bad++; $display("FAIL t3_stray_ack: got %0d want 0", stray); end
    @(negedge clk);
    bus.i_m0_cs = 0; bus.i_m1_cs = 0; bus.i_ack = 0;
    settle(3);
  endtask

  // m1 write into the register window; the memory-bus ack must be ignored there.
  task automatic test_reg_window();
    @(negedge clk);
    bus.i_m1_cs = 1; bus.i_m1_we = 1; bus.i_m1_addr = 16'hFFF1; bus.i_m1_dat = 8'h3C;
    @(negedge clk);
    bus.i_ack = 1; bus.i_dat = 8'h77;
    #1;
    total++; if ({bus.o_reg_cs, bus.o_cs, bus.o_we} !== 3'b101) begin
      bad++; $display("FAIL t4_sel: got %b want 101", {bus.o_reg_cs, bus.o_cs, bus.o_we}); end
    total++; if (bus.o_dat !== 8'h3C) begin bad++; $display("FAIL t4_wdat: got %h want 3c", bus.o_dat); end
    total++; if (bus.o_m1_ack !== 1'b0) begin bad++; $display("FAIL t4_mem_ack_ignored: got %b want 0", bus.o_m1_ack); end
    @(negedge clk);
    bus.i_ack = 0; bus.i_reg_ack = 1;
    #1;
    total++; if (bus.o_m1_ack !== 1'b1) begin bad++; $display("FAIL t4_reg_ack: got %b want 1", bus.o_m1_ack); end
    @(negedge clk);
    bus.i_m1_cs = 0; bus.i_reg_ack = 0;
    settle(1);
    bus.i_m1_cs = 1; bus.i_m1_we = 0; bus.i_m1_addr = 16'hFFF2;
    @(negedge clk);
    bus.i_ack = 1; bus.i_dat = 8'h5E;
    #1;
    total++; if ({bus.o_reg_cs, bus.o_cs} !== 2'b01) begin bad++; $display("FAIL t4_fff2_sel: got %b want 01", {bus.o_reg_cs, bus.o_cs}); end
    total++; if (bus.o_rd_dat !== 8'h5E) begin bad++; $display("FAIL t4_fff2_rd: got %h want 5e", bus.o_rd_dat); end
    @(negedge clk);
    bus.i_m1_cs = 0; bus.i_ack = 0;
    settle(2);
  endtask

  // Reset asserted during a GNT1 access with an ack pending on the bus.
  task automatic test_reset_mid();
    @(negedge clk);
    bus.i_m1_cs = 1; bus.i_m1_addr = 16'h0300;
    @(negedge clk);
    #1;
    total++; if (bus.o_grant !== 2'b10) begin bad++; $display("FAIL t5_pre_grant: got %b want 10", bus.o_grant); end
    bus.i_ack = 1; bus.i_dat = 8'hC3;
    rst_n = 0;
    #1;
    total++; if ({bus.o_cs, bus.o_m1_ack, bus.o_m0_ack, bus.o_grant} !== 5'b0) begin
      bad++; $display("FAIL t5_reset_out: got %b want 00000", {bus.o_cs, bus.o_m1_ack, bus.o_m0_ack, bus.o_grant}); end
    total++; if ({bus.o_addr, bus.o_rd_dat} !== 24'h0) begin bad++; $display("FAIL t5_reset_data: got %h want 0", {bus.o_addr, bus.o_rd_dat}); end
    @(negedge clk);
    bus.i_m1_cs = 0; bus.i_ack = 0;
    rst_n = 1;
    #1;
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL t5_state_idle: got %0d want 0", dbg_state); end
    bus.i_m0_cs = 1; bus.i_m0_addr = 16'h0500; bus.i_m1_cs = 1; bus.i_m1_addr = 16'h0600;
    @(negedge clk);
    #1;
    total++; if (bus.o_grant !== 2'b01) begin bad++; $display("FAIL t5_after_grant: got %b want 01", bus.o_grant); end
    bus.i_ack = 1;
    @(negedge clk);
    bus.i_m0_cs = 0; bus.i_ack = 0;
    @(negedge clk);
    @(negedge clk);
    bus.i_ack = 1;
    @(negedge clk);
    bus.i_m1_cs = 0; bus.i_ack = 0;
    settle(2);
  endtask

  // Ack never arrives: timeout build forces an error ack, default build waits.
  task automatic test_timeout();
    int viol;
    viol = 0;
    @(negedge clk);
    bus.i_m0_cs = 1; bus.i_m0_addr = 16'h0400;
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k <= 63; k++) begin
      @(negedge clk);
      #1;
      if (bus.o_cs !== 1'b1 || bus.o_m0_ack !== 1'b0 || bus.o_err !== 1'b0) viol++;
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL t6_wait: got %0d bad cycles want 0", viol); end
    @(negedge clk);
    #1;
    total++; if ({bus.o_m0_ack, bus.o_err, bus.o_cs} !== 3'b110) begin
      bad++; $display("FAIL t6_expire: got %b want 110", {bus.o_m0_ack, bus.o_err, bus.o_cs}); end
    total++; if (bus.o_rd_dat !== 8'hFF) begin bad++; $display("FAIL t6_rd_ff: got %h want ff", bus.o_rd_dat); end
    @(negedge clk);
    bus.i_m0_cs = 0;
    #1;
    total++; if (bus.o_err !== 1'b0) begin bad++; $display("FAIL t6_err_once: got %b want 0", bus.o_err); end
`else
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      #1;
      if (bus.o_cs !== 1'b1 || bus.o_m0_ack !== 1'b0 || bus.o_err !== 1'b0) viol++;
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL t6_hold: got %0d bad cycles want 0", viol); end
    @(negedge clk);
    bus.i_m0_cs = 0;
    #1;
    total++; if ({bus.o_cs, bus.o_m0_ack} !== 2'b00) begin bad++; $display("FAIL t6_abort: got %b want 00", {bus.o_cs, bus.o_m0_ack}); end
`endif
    settle(2);
  endtask

  // Master abandons its access before any ack: no ack, selects drop at once.
  task automatic test_abort();
    @(negedge clk);
    bus.i_m1_cs = 1; bus.i_m1_we = 1; bus.i_m1_addr = 16'hFFF0; bus.i_m1_dat = 8'h01;
    @(negedge clk);
    #1;
    total++; if (bus.o_reg_cs !== 1'b1) begin bad++; $display("FAIL t7_reg_sel: got %b want 1", bus.o_reg_cs); end
    bus.i_m1_cs = 0; bus.i_reg_ack = 1;
    #1;
    total++; if ({bus.o_reg_cs, bus.o_we, bus.o_m1_ack} !== 3'b000) begin
      bad++; $display("FAIL t7_abort: got %b want 000", {bus.o_reg_cs, bus.o_we, bus.o_m1_ack}); end
    @(negedge clk);
    bus.i_reg_ack = 0;
    #1;
    total++; if (bus.o_grant !== 2'b00) begin bad++; $display("FAIL t7_done: got %b want 00", bus.o_grant); end
    settle(2);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_m0_read();
    test_simultaneous();
    test_starvation();
    test_reg_window();
    test_reset_mid();
    test_timeout();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
